// File: rtl/counter_offset_down_reader.sv
// rtl/counter_offset_down_reader.sv - down-counting read address sequencer with valid/ready handshake
// Optional burst abort port enabled by defining COUNTER_OFFSET_ABORT_EN.
module counter_offset_down_reader #(
  parameter int BITWIDTH = 10
) (
  input  logic                COUNTER_OFFSET_Clk,
  input  logic                COUNTER_OFFSET_Clr,
  input  logic                COUNTER_OFFSET_Start,
  input  logic [BITWIDTH-1:0] COUNTER_OFFSET_offset,
  input  logic [BITWIDTH-1:0] COUNTER_OFFSET_Number,
  input  logic                COUNTER_OFFSET_Ready,
`ifdef COUNTER_OFFSET_ABORT_EN
  input  logic                COUNTER_OFFSET_Abort,
`endif
  output logic [BITWIDTH-1:0] COUNTER_OFFSET_Out,
  output logic                COUNTER_OFFSET_Valid,
  output logic                COUNTER_OFFSET_Zero_Flag,
  output logic                COUNTER_OFFSET_Busy,
  output logic                COUNTER_OFFSET_Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BITWIDTH-1:0] r_count;
  logic [BITWIDTH-1:0] r_base;
  logic [BITWIDTH-1:0] w_count_nxt;
  logic [BITWIDTH-1:0] w_base_nxt;
  logic                w_valid;
  logic                w_hs;
  logic                w_count_zero;
  logic                w_abort;

`ifdef COUNTER_OFFSET_ABORT_EN
  assign w_abort = COUNTER_OFFSET_Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_valid      = (r_state == S_RUN);
  assign w_hs         = w_valid && COUNTER_OFFSET_Ready;
  assign w_count_zero = (r_count == '0);

  always_ff @(posedge COUNTER_OFFSET_Clk or negedge COUNTER_OFFSET_Clr) begin
    if (!COUNTER_OFFSET_Clr) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_base  <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_base_nxt  = r_base;
    unique case (r_state)
      S_IDLE: begin
        // Abort is deliberately not looked at here so it cannot block a start.
        if (COUNTER_OFFSET_Start) begin
          w_base_nxt  = COUNTER_OFFSET_offset;
          w_count_nxt = COUNTER_OFFSET_Number;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (w_hs) begin
          if (w_count_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count - BITWIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_abort) begin
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Outputs decode registered state only; carry out of the address add is dropped.
  assign COUNTER_OFFSET_Out       = r_base + r_count;
  assign COUNTER_OFFSET_Valid     = w_valid;
  assign COUNTER_OFFSET_Zero_Flag = w_valid && w_count_zero;
  assign COUNTER_OFFSET_Busy      = (r_state != S_IDLE);
  assign COUNTER_OFFSET_Done      = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_offset_down_reader.sv
// tb/tb_counter_offset_down_reader.sv - scoreboard bench for counter_offset_down_reader
// Abort scenarios are exercised when COUNTER_OFFSET_ABORT_EN is defined.
module tb_counter_offset_down_reader;
  localparam int BW = 10;

  logic          clk    = 1'b0;
  logic          clr_n  = 1'b0;
  logic          start  = 1'b0;
  logic          ready  = 1'b0;
  logic          abort  = 1'b0;
  logic [BW-1:0] offset = '0;
  logic [BW-1:0] number = '0;
  logic [BW-1:0] out;
  logic          valid;
  logic          zero;
  logic          busy;
  logic          done;

  typedef struct {
    logic [BW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks       = 0;
  int   errors       = 0;
  int   exp_busy_len = 0;
  int   tmo_cnt      = 0;
  bit   end_req      = 1'b0;
  bit   prev_final   = 1'b0;
  int   busy_run     = 0;

  always #5 clk = ~clk;

  counter_offset_down_reader #(.BITWIDTH(BW)) dut (
    .COUNTER_OFFSET_Clk       (clk),
    .COUNTER_OFFSET_Clr       (clr_n),
    .COUNTER_OFFSET_Start     (start),
    .COUNTER_OFFSET_offset    (offset),
    .COUNTER_OFFSET_Number    (number),
    .COUNTER_OFFSET_Ready     (ready),
`ifdef COUNTER_OFFSET_ABORT_EN
    .COUNTER_OFFSET_Abort     (abort),
`endif
    .COUNTER_OFFSET_Out       (out),
    .COUNTER_OFFSET_Valid     (valid),
    .COUNTER_OFFSET_Zero_Flag (zero),
    .COUNTER_OFFSET_Busy      (busy),
    .COUNTER_OFFSET_Done      (done)
  );

  // Monitor: sole owner of the check/error counters.
  always begin
    bit   final_now;
    exp_t e;
    @(negedge clk or negedge clr_n);
    #1;
    final_now = 1'b0;
    if (!clr_n) begin
      checks++;
      if ({out, valid, zero, busy, done} != '0) begin
        errors++;
        $display("FAIL reset_outputs: out=%0d valid=%0b zero=%0b busy=%0b done=%0b, required all 0",
                 out, valid, zero, busy, done);
      end
      prev_final = 1'b0;
      busy_run   = 0;
    end else begin
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: out=%0d, required no valid", out);
        end else begin
          e = exp_q[0];
          if (out != e.addr || zero != e.last) begin
            errors++;
            $display("FAIL addr: out=%0d zero=%0b, required out=%0d zero=%0b",
                     out, zero, e.addr, e.last);
          end
          if (ready) begin
            final_now = e.last;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        checks++;
        if (zero) begin
          errors++;
          $display("FAIL zero_without_valid: zero=%0b, required 0", zero);
        end
      end
      checks++;
      if (done != prev_final) begin
        errors++;
        $display("FAIL done: done=%0b, required %0b", done, prev_final);
      end
      prev_final = final_now;
      if (busy) begin
        busy_run++;
      end else begin
        if (busy_run > 0 && exp_busy_len > 0) begin
          checks++;
          if (busy_run != exp_busy_len) begin
            errors++;
            $display("FAIL busy_len: busy cycles=%0d, required %0d", busy_run, exp_busy_len);
          end
        end
        busy_run = 0;
      end
    end
    if (end_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drained: %0d addresses left, required 0", exp_q.size());
      end
      checks++;
      if (tmo_cnt != 0) begin
        errors++;
        $display("FAIL timeout: %0d bursts timed out, required 0", tmo_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic push_burst(input logic [BW-1:0] off, input logic [BW-1:0] num);
    exp_t e;
    for (int i = int'(num); i >= 0; i--) begin
      e.addr = off + BW'(i);
      e.last = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_burst(input logic [BW-1:0] off, input logic [BW-1:0] num,
                           input logic [BW-1:0] stall_addr, input int stall_len,
                           input int inject_at, input int abort_at);
    int vcount;
    int stall_left;
    bit aborted;
    bit fin;
    @(posedge clk);
    #1;
    exp_busy_len = (abort_at != 0) ? 0 : int'(num) + 2 + stall_len;
    start  = 1'b1;
    offset = off;
    number = num;
    ready  = 1'b1;
    push_burst(off, num);
    @(posedge clk);
    #1;
    start      = 1'b0;
    vcount     = 0;
    stall_left = stall_len;
    aborted    = 1'b0;
    fin        = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (aborted) begin
        exp_q.delete();
        abort = 1'b0;
        fin   = 1'b1;
      end else if (!busy) begin
        fin = 1'b1;
      end else begin
        if (valid) vcount++;
        ready = !(valid && out == stall_addr && stall_left > 0);
        if (!ready) stall_left--;
        start = (valid && vcount == inject_at);
        if (start) begin
          offset = 10'd100;
          number = 10'd4;
        end
        abort = (valid && abort_at != 0 && vcount == abort_at);
        if (abort) begin
          ready   = 1'b1;
          aborted = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    if (!fin) tmo_cnt++;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
  endtask

  initial begin
    clr_n  = 1'b0;
    start  = 1'b1;
    ready  = 1'b1;
    offset = 10'd5;
    number = 10'd3;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    run_burst(10'd5,    10'd3, 10'd0, 0, 0, 0);   // 8,7,6,5
    run_burst(10'd5,    10'd3, 10'd7, 2, 0, 0);   // 8,7,7,7,6,5
    run_burst(10'd1020, 10'd5, 10'd0, 0, 0, 0);   // 1,0,1023,1022,1021,1020
    run_burst(10'd40,   10'd6, 10'd0, 0, 3, 0);   // start in RUN ignored
    run_burst(10'd300,  10'd0, 10'd0, 0, 0, 0);   // single address
`ifdef COUNTER_OFFSET_ABORT_EN
    run_burst(10'd0,    10'd7, 10'd0, 0, 0, 2);   // abort on second valid
    run_burst(10'd3,    10'd4, 10'd0, 0, 0, 0);   // clean restart
`endif

    // Asynchronous reset in the middle of a burst.
    @(posedge clk);
    #1;
    exp_busy_len = 0;
    start  = 1'b1;
    offset = 10'd200;
    number = 10'd9;
    push_burst(10'd200, 10'd9);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    clr_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    run_burst(10'd12, 10'd1, 10'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    end_req = 1'b1;
    #200;
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1);
  end

endmodule
